mult_hilo_ctrl: RTL
===================

# mult_hilo_ctrl

Multi-cycle sequencer for the 32×32 multiplier datapath in the execute stage. It accepts MULT/MULTU (and MADD/MADDU when configured) issues from the pipeline and holds the operands stable for a fixed number of cycles. It owns the architectural HI/LO registers, services MTHI/MTLO/MFHI/MFLO, and stalls the pipeline while a product is in flight.

## Interface
Parameters:
- LATENCY, 3, cycles from accepted issue to HI/LO update; legal range 1..15.

Ports:
- clk  in  1  single clock; all state changes on rising edge
- reset  in  1  asynchronous, active-high; forces idle state and clears HI/LO
- i_start  in  1  issue multiply; sampled only when idle
- i_is_unsigned  in  1  1 = MULTU/MADDU, 0 = signed
- i_accumulate  in  1  1 = MADD/MADDU (add product to {HI,LO}); ignored unless MULT_MADD_EN
- i_opr1, i_opr2  in  32  multiplicand, multiplier
- i_cancel  in  1  pipeline flush; aborts in-flight multiply
- i_mthi, i_mtlo  in  1  write i_wdata into HI / LO
- i_wdata  in  32  MTHI/MTLO data
- i_mf_req  in  1  MFHI/MFLO in execute; needs settled HI/LO
- o_busy  out  1  multiply in flight
- o_stall  out  1  combinational stall request to the pipeline
- o_done  out  1  one-cycle pulse; HI/LO hold a new product
- o_hi, o_lo  out  32  architectural HI, LO

## Operation
- States: IDLE, CALC. Reset → IDLE, cnt = 0, opr/mode regs = 0, HI = LO = 0, o_done = 0.
- IDLE & i_start & ~i_cancel: latch i_opr1, i_opr2, i_is_unsigned, i_accumulate. Set cnt = LATENCY-1. Go to CALC.
- CALC & cnt != 0: decrement cnt.
- CALC & cnt == 0 & ~i_cancel: write the product from the latched operands to {HI,LO}, pulse o_done, go to IDLE.
- Product is the full 64-bit result:
  - signed mode: two's-complement product of the sign-extended operands.
  - unsigned mode: zero-extended operands.
  - HI = bits [63:32], LO = bits [31:0].
- Accumulate (macro on): {HI,LO} ← {HI,LO} + product, modulo 2^64.
- i_cancel in CALC: go to IDLE. HI/LO are unchanged and o_done is not pulsed. This also applies on the final count, so cancel beats completion.
- i_cancel in IDLE blocks a same-cycle i_start, i_mthi and i_mtlo.
- MTHI/MTLO in IDLE: write on that edge. If i_start is asserted in the same cycle, i_start wins and the MT write is dropped; the decoder never issues both.
- o_stall = (state == CALC) & ~i_cancel & (i_start | i_mf_req | i_mthi | i_mtlo).
  - While stalled, the requesting instruction is held upstream and re-presented.
  - i_start, i_mthi and i_mtlo in CALC are ignored by this block.
- o_busy = (state == CALC).

## Timing
- Issue sampled at edge E0. o_busy is high for LATENCY cycles (after E0 through E_LATENCY).
- HI/LO are updated at E_LATENCY. o_done is high for the cycle after E_LATENCY, coincident with the new values.
- Back-to-back issue: a new i_start is accepted in the first IDLE cycle after completion, i.e. the cycle o_done is high. Throughput is one multiply per LATENCY+1 cycles.
- MFHI/MFLO issued during CALC stalls until IDLE and then reads the updated value. No bypass of the in-flight product.
- Reset asserted mid-operation: immediate return to IDLE, HI/LO = 0, o_done = 0, o_busy = 0, o_stall = 0.
- Latched operands must not change during CALC: the combinational product settles over the LATENCY-cycle multicycle path.

## Configuration
- MULT_MADD_EN defined:
  - i_accumulate is latched at issue.
  - MADD/MADDU add the product into {HI,LO} at completion using a 64-bit adder.
- MULT_MADD_EN undefined:
  - i_accumulate is ignored and the accumulate logic is not built.
  - Every completion overwrites {HI,LO} with the product.

## Test plan
- Signed -3 × 7 (0xFFFFFFFD, 0x00000007), LATENCY=3 → o_busy high 3 cycles; then o_done for 1 cycle with HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- Unsigned 0xFFFFFFFF × 0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001. Signed 0x80000000 × 0x80000000 → HI=0x40000000, LO=0x00000000.
- MTHI 0x12345678, MTLO 0x9ABCDEF0 while idle; start a multiply; assert i_mf_req during CALC → o_stall high every CALC cycle. After completion, HI/LO hold the product, not the MT values.
- Start 5 × 5, assert i_cancel on the last CALC cycle → no o_done; HI/LO keep prior values; idle next cycle.
- MULT_MADD_EN: set HI=0x00000000, LO=0xFFFFFFFF; MADDU 1 × 1 → HI=0x00000001, LO=0x00000000. Without the macro, the same stimulus → HI=0x00000000, LO=0x00000001.
- Assert reset two cycles into CALC → all outputs 0 immediately. A start after release completes normally.

Source files
------------

// File: rtl/mult_hilo_ctrl.sv
// Multi-cycle sequencer for the 32x32 multiplier: holds operands for LATENCY cycles and owns HI/LO.
// Optional MADD/MADDU accumulation is built when the MULT_MADD_EN macro is defined.
module mult_hilo_ctrl #(
  parameter int LATENCY = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_start,
  input  logic        i_is_unsigned,
  input  logic        i_accumulate,
  input  logic [31:0] i_opr1,
  input  logic [31:0] i_opr2,
  input  logic        i_cancel,
  input  logic        i_mthi,
  input  logic        i_mtlo,
  input  logic [31:0] i_wdata,
  input  logic        i_mf_req,
  output logic        o_busy,
  output logic        o_stall,
  output logic        o_done,
  output logic [31:0] o_hi,
  output logic [31:0] o_lo
);

  typedef enum logic {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_t;

  state_t      state_reg, state_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic [31:0] opr1_reg, opr2_reg;
  logic        unsigned_reg;
  logic [31:0] hi_reg, lo_reg;
  logic        done_reg;
  logic        accept, finish, mthi_en, mtlo_en;
  logic [63:0] ext1, ext2, product, result;

  assign accept  = (state_reg == IDLE) & i_start & ~i_cancel;
  assign finish  = (state_reg == CALC) & (cnt_reg == 4'd0) & ~i_cancel;
  // An issue in the same cycle wins over MTHI/MTLO.
  assign mthi_en = (state_reg == IDLE) & i_mthi & ~i_start & ~i_cancel;
  assign mtlo_en = (state_reg == IDLE) & i_mtlo & ~i_start & ~i_cancel;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= 4'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Next-state logic; cancel beats completion on the final count
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          state_next = CALC;
          cnt_next   = 4'(LATENCY - 1);
        end
      end
      CALC: begin
        if (i_cancel) begin
          state_next = IDLE;
          cnt_next   = 4'd0;
        end else if (cnt_reg != 4'd0) begin
          cnt_next = cnt_reg - 4'd1;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    o_busy  = (state_reg == CALC);
    o_stall = (state_reg == CALC) & ~i_cancel & (i_start | i_mf_req | i_mthi | i_mtlo);
  end

  // Operands stay frozen during CALC so the product settles over the multicycle path.
  assign ext1    = unsigned_reg ? {32'd0, opr1_reg} : {{32{opr1_reg[31]}}, opr1_reg};
  assign ext2    = unsigned_reg ? {32'd0, opr2_reg} : {{32{opr2_reg[31]}}, opr2_reg};
  assign product = ext1 * ext2;

`ifdef MULT_MADD_EN
  logic acc_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_reg <= 1'b0;
    end else if (accept) begin
      acc_reg <= i_accumulate;
    end
  end

  assign result = acc_reg ? ({hi_reg, lo_reg} + product) : product;
`else
  logic unused_accumulate;
  assign unused_accumulate = i_accumulate;
  assign result            = product;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      opr1_reg     <= 32'd0;
      opr2_reg     <= 32'd0;
      unsigned_reg <= 1'b0;
      hi_reg       <= 32'd0;
      lo_reg       <= 32'd0;
      done_reg     <= 1'b0;
    end else begin
      done_reg <= finish;
      if (accept) begin
        opr1_reg     <= i_opr1;
        opr2_reg     <= i_opr2;
        unsigned_reg <= i_is_unsigned;
      end
      if (finish) begin
        hi_reg <= result[63:32];
        lo_reg <= result[31:0];
      end else begin
        if (mthi_en) hi_reg <= i_wdata;
        if (mtlo_en) lo_reg <= i_wdata;
      end
    end
  end

  assign o_done = done_reg;
  assign o_hi   = hi_reg;
  assign o_lo   = lo_reg;

endmodule
